s_io_responder: RTL
===================

Name: s_io_responder

Overview:
- Bus responder for the SPC700 I/O page $F0-$FF. It is the target side of the S-CPU's memory bus requests.
- Holds the following:
  - TEST/CONTROL
  - DSP address/data window
  - the four CPUIO mailbox ports shared with the main CPU
  - two RAM registers
  - the three APU timers
- Sits between the S-CPU datapath, the DSP register file and the main-CPU $2140-$2143 interface.

Parameters:
- T01_DIV, 128, SMP cycles per stage tick for timers 0/1 (8 kHz).
- T2_DIV, 16, SMP cycles per stage tick for timer 2 (64 kHz); must divide T01_DIV.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_en  in  1  SMP cycle enable; all S-CPU-side state changes are qualified by it
- sel  in  1  S-CPU access targets $F0-$FF this cycle
- addr  in  4  low nibble of the S-CPU address
- rd  in  1  S-CPU read strobe
- wr  in  1  S-CPU write strobe
- wdata  in  8  S-CPU write data
- rdata  out  8  read data, combinational from addr/state
- main_addr  in  2  main-CPU port index ($2140+n)
- main_rd  in  1  main-CPU read (no side effects)
- main_wr  in  1  main-CPU write strobe, not qualified by cpu_en
- main_wdata  in  8  main-CPU write data
- main_rdata  out  8  out-latch[main_addr], combinational
- dsp_addr  out  8  current DSPADDR
- dsp_wr  out  1  one-cycle DSP register write pulse
- dsp_wdata  out  8  DSP write data
- dsp_rdata  in  8  DSP register read data
- ipl_en  out  1  IPL ROM mapped at $FFC0-$FFFF

Behaviour:
- Reset (async, reset_n=0):
  - ipl_en=1; timer enables=0; DSPADDR=0.
  - In/out latches=0; RAM regs=0; targets=0; stages=0; counters=0; prescaler=0; dsp_wr=0.
- S-CPU access takes effect at a clk edge with cpu_en & sel & (rd|wr); rd and wr are never both high.
- Register map (addr):
  - 0 TEST: write ignored, read 0.
  - 1 CONTROL, write-only (read 0):
    - bits2:0 timer enables; a 0->1 edge clears that timer's stage and counter.
    - bit4=1 clears in-latch 0,1.
    - bit5=1 clears in-latch 2,3.
    - bit7 -> ipl_en.
  - 2 DSPADDR: read/write.
  - 3 DSPDATA:
    - read returns dsp_rdata.
    - write pulses dsp_wr for exactly one clk with dsp_wdata=wdata, only if DSPADDR[7]=0.
    - A write with DSPADDR[7]=1 is dropped.
  - 4-7 CPUIO n:
    - read returns in-latch[n], written by main CPU.
    - write sets out-latch[n], read by main CPU.
  - 8-9: plain r/w RAM regs.
  - A-C target 0..2: write-only, read 0.
  - D-F counter 0..2: read returns {4'h0,cnt}; read clears cnt.
- main_wr sets in-latch[main_addr]=main_wdata in that clk.
  - A main_wr and a CONTROL clear of the same latch in one edge: main_wr wins.
- Prescaler:
  - Free-running mod T01_DIV, advanced on cpu_en; not reset by enable edges.
  - tick01 when prescaler wraps to 0; tick2 when prescaler mod T2_DIV wraps.
- Timer n (enabled only):
  - On its tick, stage+1.
  - When the new stage equals target (target 0 means 256), stage<=0 and cnt<=cnt+1 mod 16.
  - A disabled timer holds stage and cnt.
- Counter read coinciding with an increment: rdata shows the pre-increment value and cnt becomes 1.
- Writing a target mid-count takes effect at the next compare; no stage reset.
- Reset_n asserted mid-operation: everything returns to reset values immediately, including dsp_wr=0.
- Accesses with cpu_en=0 have no effect; rdata is still driven.

Decomposition:
- Shared package s_cpu_pkg gains:
  - io register index constants (IO_TEST..IO_CNT2)
  - CONTROL bit positions
  - T01_DIV/T2_DIV defaults
- One sub-module, s_timer: enable, tick, target, clear, read-clear in; 4-bit cnt out. Instantiated three times.

Test Plan:
- Reset then read $F1,$F4,$FD -> rdata 0,0,0; ipl_en=1.
- main_wr port1=8'hAA -> S-CPU read $F5 gives AA. Then write $F1=8'h10 -> $F5 reads 00 and ipl_en=0.
- Write $F2=8'h4C, $F3=8'h5A -> single dsp_wr pulse, dsp_addr=4C, dsp_wdata=5A. Write $F2=8'hCC, $F3=8'h11 -> no dsp_wr.
- Target0=2, enable timer0 via $F1=01, run 4*T01_DIV SMP cycles -> $FD reads 2, then reads 0.
- Target2=0 (=256), enable T2, run 256*16*17 cycles -> $FF reads 1 (17 mod 16). Read $FF on the exact increment cycle -> old value returned, next read 1.
- Main write port2 and $F1=8'h20 on the same edge -> in-latch2 holds main data. Assert reset_n mid DSP write -> dsp_wr drops immediately.

Source files
------------

// File: rtl/s_cpu_pkg.sv
// Shared definitions for the SPC700 side: I/O page register indices, CONTROL bit
// positions and default timer prescaler ratios.
package s_cpu_pkg;

    localparam int unsigned T01_DIV_DEF = 128;
    localparam int unsigned T2_DIV_DEF  = 16;
    localparam int unsigned NUM_TIMERS  = 3;

    // Low nibble of the $F0-$FF I/O page
    typedef enum logic [3:0] {
        IO_TEST    = 4'h0,
        IO_CONTROL = 4'h1,
        IO_DSPADDR = 4'h2,
        IO_DSPDATA = 4'h3,
        IO_CPUIO0  = 4'h4,
        IO_CPUIO1  = 4'h5,
        IO_CPUIO2  = 4'h6,
        IO_CPUIO3  = 4'h7,
        IO_RAM0    = 4'h8,
        IO_RAM1    = 4'h9,
        IO_T0TGT   = 4'hA,
        IO_T1TGT   = 4'hB,
        IO_T2TGT   = 4'hC,
        IO_CNT0    = 4'hD,
        IO_CNT1    = 4'hE,
        IO_CNT2    = 4'hF
    } io_reg_e;

    localparam int unsigned CTRL_CLR01 = 4;
    localparam int unsigned CTRL_CLR23 = 5;
    localparam int unsigned CTRL_IPL   = 7;

    // A target of zero stands for a full 256-tick period
    function automatic logic [8:0] tgt_limit(input logic [7:0] tgt);
        return (tgt == 8'd0) ? 9'd256 : {1'b0, tgt};
    endfunction

endpackage

// File: rtl/s_timer.sv
// One APU timer: 8-bit stage counting prescaler ticks up to a target, and a
// 4-bit output counter that is cleared by reading it.
module s_timer
    import s_cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       tick,
    input  logic [7:0] target,
    input  logic       clear,
    input  logic       rd_clr,
    output logic [3:0] cnt
);

    logic [7:0] stage_q, stage_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] stage_inc;
    logic       hit;

    always_comb begin
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        stage_inc = {1'b0, stage_q} + 9'd1;
        hit       = 1'b0;
        if (clear) begin
            stage_d = 8'd0;
            cnt_d   = 4'd0;
        end else begin
            if (enable && tick) begin
                if (stage_inc == tgt_limit(target)) begin
                    stage_d = 8'd0;
                    hit     = 1'b1;
                end else begin
                    stage_d = stage_inc[7:0];
                end
            end
            // A read racing an increment still reports the old value, so keep the new count
            if (rd_clr) begin
                cnt_d = hit ? 4'd1 : 4'd0;
            end else if (hit) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= 8'd0;
            cnt_q   <= 4'd0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/s_io_responder.sv
// Target side of the S-CPU $F0-$FF I/O page: CONTROL, DSP window, CPUIO mailboxes,
// RAM registers and the three APU timers with their shared prescaler.
module s_io_responder
    import s_cpu_pkg::*;
#(
    parameter int unsigned T01_DIV = T01_DIV_DEF,
    parameter int unsigned T2_DIV  = T2_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cpu_en,
    input  logic       sel,
    input  logic [3:0] addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic [1:0] main_addr,
    input  logic       main_rd,
    input  logic       main_wr,
    input  logic [7:0] main_wdata,
    output logic [7:0] main_rdata,
    output logic [7:0] dsp_addr,
    output logic       dsp_wr,
    output logic [7:0] dsp_wdata,
    input  logic [7:0] dsp_rdata,
    output logic       ipl_en
);

    localparam int unsigned PW = (T01_DIV > 1) ? $clog2(T01_DIV) : 1;

    logic [3:0][7:0] in_q, in_d;
    logic [3:0][7:0] out_q, out_d;
    logic [1:0][7:0] ram_q, ram_d;
    logic [2:0][7:0] tgt_q, tgt_d;
    logic [2:0]      en_q, en_d;
    logic            ipl_q, ipl_d;
    logic [7:0]      dspaddr_q, dspaddr_d;
    logic [7:0]      dsp_wdata_q, dsp_wdata_d;
    logic            dsp_wr_q, dsp_wr_d;
    logic [PW-1:0]   presc_q, presc_d;

    logic            access, wr_acc, rd_acc;
    logic            tick01, tick2;
    logic [2:0]      tmr_clr;
    logic [2:0]      cnt_rd;
    logic [3:0]      cnt [3];

    assign access = cpu_en & sel & (rd | wr);
    assign wr_acc = access & wr;
    assign rd_acc = access & rd;

    assign cnt_rd = {rd_acc && (addr == IO_CNT2),
                     rd_acc && (addr == IO_CNT1),
                     rd_acc && (addr == IO_CNT0)};

    // Prescaler free-runs on cpu_en; enable edges never touch it
    always_comb begin
        presc_d = presc_q;
        tick01  = 1'b0;
        tick2   = 1'b0;
        if (cpu_en) begin
            tick01  = (presc_q == PW'(T01_DIV - 1));
            tick2   = ((32'(presc_q) % T2_DIV) == (T2_DIV - 1));
            presc_d = tick01 ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        in_d        = in_q;
        out_d       = out_q;
        ram_d       = ram_q;
        tgt_d       = tgt_q;
        en_d        = en_q;
        ipl_d       = ipl_q;
        dspaddr_d   = dspaddr_q;
        dsp_wdata_d = dsp_wdata_q;
        dsp_wr_d    = 1'b0;
        tmr_clr     = 3'b000;
        if (wr_acc) begin
            case (addr)
                IO_CONTROL: begin
                    en_d    = wdata[2:0];
                    tmr_clr = wdata[2:0] & ~en_q;
                    if (wdata[CTRL_CLR01]) in_d[1:0] = '0;
                    if (wdata[CTRL_CLR23]) in_d[3:2] = '0;
                    ipl_d = wdata[CTRL_IPL];
                end
                IO_DSPADDR: dspaddr_d = wdata;
                IO_DSPDATA: begin
                    // DSP addresses $80-$FF are read-only mirrors
                    if (!dspaddr_q[7]) begin
                        dsp_wr_d    = 1'b1;
                        dsp_wdata_d = wdata;
                    end
                end
                IO_CPUIO0, IO_CPUIO1, IO_CPUIO2, IO_CPUIO3: out_d[addr[1:0]] = wdata;
                IO_RAM0, IO_RAM1: ram_d[addr[0]] = wdata;
                IO_T0TGT: tgt_d[0] = wdata;
                IO_T1TGT: tgt_d[1] = wdata;
                IO_T2TGT: tgt_d[2] = wdata;
                default: ;
            endcase
        end
        // Main-CPU write overrides a same-edge CONTROL latch clear
        if (main_wr) in_d[main_addr] = main_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q        <= '0;
            out_q       <= '0;
            ram_q       <= '0;
            tgt_q       <= '0;
            en_q        <= 3'b000;
            ipl_q       <= 1'b1;
            dspaddr_q   <= 8'h00;
            dsp_wdata_q <= 8'h00;
            dsp_wr_q    <= 1'b0;
            presc_q     <= '0;
        end else begin
            in_q        <= in_d;
            out_q       <= out_d;
            ram_q       <= ram_d;
            tgt_q       <= tgt_d;
            en_q        <= en_d;
            ipl_q       <= ipl_d;
            dspaddr_q   <= dspaddr_d;
            dsp_wdata_q <= dsp_wdata_d;
            dsp_wr_q    <= dsp_wr_d;
            presc_q     <= presc_d;
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
        s_timer u_timer (
            .clk     (clk),
            .reset_n (reset_n),
            .enable  (en_q[i]),
            .tick    ((i < 2) ? tick01 : tick2),
            .target  (tgt_q[i]),
            .clear   (tmr_clr[i]),
            .rd_clr  (cnt_rd[i]),
            .cnt     (cnt[i])
        );
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            IO_DSPADDR: rdata = dspaddr_q;
            IO_DSPDATA: rdata = dsp_rdata;
            IO_CPUIO0:  rdata = in_q[0];
            IO_CPUIO1:  rdata = in_q[1];
            IO_CPUIO2:  rdata = in_q[2];
            IO_CPUIO3:  rdata = in_q[3];
            IO_RAM0:    rdata = ram_q[0];
            IO_RAM1:    rdata = ram_q[1];
            IO_CNT0:    rdata = {4'h0, cnt[0]};
            IO_CNT1:    rdata = {4'h0, cnt[1]};
            IO_CNT2:    rdata = {4'h0, cnt[2]};
            default:    rdata = 8'h00;
        endcase
    end

    assign main_rdata = out_q[main_addr];
    assign dsp_addr   = dspaddr_q;
    assign dsp_wr     = dsp_wr_q;
    assign dsp_wdata  = dsp_wdata_q;
    assign ipl_en     = ipl_q;

endmodule
